fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Upstream stage of instruction_mem.
- Owns the program counter and drives instruction_mem's address.
- Captures the returned instruction word and presents {pc, instruction} to decode over a valid/ready handshake.
- Supports branch redirect with squash, downstream backpressure via a one-entry skid buffer, and an end-of-memory halt.

Parameters:
RESET_PC, 0, byte address fetched first after reset
MEM_WORDS, 1024, instruction memory depth in words; fetch limit is MEM_WORDS*4 bytes

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
imem_address  output  `WORD  byte address to instruction_mem, combinational from pc register
imem_instruction  input  `INSTR_LEN  instruction_mem read data, valid the cycle after the address is sampled
out_valid  output  1  out_instruction/out_pc valid
out_ready  input  1  decode accepts this cycle
out_instruction  output  `INSTR_LEN  fetched instruction
out_pc  output  `WORD  byte address of out_instruction
redirect_valid  input  1  one-cycle branch/jump redirect
redirect_target  input  `WORD  redirect byte address
halted  output  1  fetch stopped and all buffers empty

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state is sampled on posedge clk.
- Reset values: pc=RESET_PC, out_valid=0, skid empty, pending=0, squash=0, halted=0, out_instruction=0, out_pc=0, state=RUN. Reset asserted mid-operation discards everything at that edge.
- Latency: address issued in cycle k; instruction_mem samples it at the end of k. Data is registered by fetch_unit at the end of k+1, so out_valid is high in k+2. Back-to-back issue gives 1 instruction per cycle.
- Issue is a request at pc. When issuing: pending<=1, pending_pc<=pc, pc<=pc+4.
- Issue condition: state==RUN, no redirect, and (out_valid + skid_valid + pending − pop) < 2, where pop = out_valid & out_ready. Capacity is 2 (output reg + skid). Data is never dropped.
- Return routing: if pending and not squash, data goes to the output reg when it is free or popping (in order: skid drains first); otherwise it goes to skid.
- Redirect, which wins over everything else:
  - Clears out_valid and skid_valid.
  - Sets squash if a request is pending, so the next returned word is discarded.
  - pc<=aligned target; state<=RUN if target < MEM_WORDS*4.
  - No issue in the redirect cycle (1 bubble).
  - If out_valid&out_ready in that same cycle, that transfer still completes.
- pc arithmetic: modulo 2^`WORD. Redirect targets are aligned by clearing bits[1:0] (see Optional Feature).
- FSM:
  - RUN: issue per rule. When pc ≥ MEM_WORDS*4 → DRAIN.
  - DRAIN: no issue; deliver buffered/pending words. When all are empty → HALTED.
  - HALTED: halted=1, out_valid=0. An in-range redirect → RUN. An out-of-range redirect stays in DRAIN/HALTED.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: redirect_target[1:0]!=0 sets a sticky fault.
  - State → DRAIN → HALTED, with buffers flushed as for a normal redirect.
  - Subsequent redirects are ignored; only reset clears the fault.
- Undefined: bits[1:0] are silently cleared and fetch continues at the aligned address.

Decomposition:
- `WORD, `INSTR_LEN, and a new `INSTR_BYTES (4) live in constants.vh.
- FSM state encodings (RUN/DRAIN/HALTED) are localparams in constants.vh so tests can reference them.
- One natural sub-module: fetch_skid_buffer, a 1-entry {pc, instruction} holding register with push/pop/flush.

Test Plan:
Memory image: word i = i, so the instruction at address A is A/4.
- Reset release, out_ready=1: first out_valid 2 cycles after issue with out_pc=0x0, instr=0; then pc 0x4/instr 1, 0x8/2 … every cycle, no gaps.
- out_ready=0 for 5 cycles while instr 3 presented: out holds 3; imem_address advances at most 2 beyond 0xC; after release, outputs 4,5,6 in order, none lost or duplicated.
- redirect_valid with target 0x100 while instr 5 valid: instr 6/7 never appear; next output is out_pc=0x100, instr 64.
- MEM_WORDS=16: last output is pc 0x3C/instr 15, then halted=1 and out_valid=0. Redirect to 0x8 then resumes with instr 2 and halted=0.
- redirect 0x102: with FETCH_ALIGN_CHECK_EN, halted=1, no further output, and a later redirect to 0x0 is ignored. Without the macro, the next output is pc 0x100/instr 64.
- reset pulsed during backpressure (skid full): out_valid=0 after the edge, then fetch restarts at pc 0x0/instr 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the fetch stage.
package fetch_unit_pkg;

  localparam int WORD        = 32;
  localparam int INSTR_LEN   = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_skid_buffer.sv
// One-entry {pc, instruction} holding register. Push wins over pop so a
// simultaneous drain-and-refill leaves the new word resident.
module fetch_skid_buffer
  import fetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD-1:0]      push_pc,
  input  logic [INSTR_LEN-1:0] push_instr,
  output logic                 valid,
  output logic [WORD-1:0]      pc,
  output logic [INSTR_LEN-1:0] instr
);

  logic                 valid_q, valid_d;
  logic [WORD-1:0]      pc_q, pc_d;
  logic [INSTR_LEN-1:0] instr_q, instr_d;

  // Next-entry selection: flush, then push, then pop.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      pc_d    = push_pc;
      instr_d = push_instr;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Entry register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues to instruction memory (1-cycle read),
// and hands {pc, instruction} to decode over valid/ready. Up to two words
// are held (output register + skid) so no returned data is ever dropped.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target sets a
// sticky fault that drains and halts fetch until reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC  = '0,
  parameter int              MEM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [WORD-1:0]      imem_address,
  input  logic [INSTR_LEN-1:0] imem_instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_LEN-1:0] out_instruction,
  output logic [WORD-1:0]      out_pc,
  input  logic                 redirect_valid,
  input  logic [WORD-1:0]      redirect_target,
  output logic                 halted
);

  localparam logic [WORD-1:0] LIMIT = WORD'(MEM_WORDS * INSTR_BYTES);

  logic [WORD-1:0]      pc_q, pc_d;
  logic                 out_valid_q, out_valid_d;
  logic [INSTR_LEN-1:0] out_instr_q, out_instr_d;
  logic [WORD-1:0]      out_pc_q, out_pc_d;
  logic                 pending_q, pending_d;
  logic [WORD-1:0]      pending_pc_q, pending_pc_d;
  logic                 squash_q, squash_d;
  fetch_state_e         state_q, state_d;

  logic                 skid_valid, skid_flush, skid_push, skid_pop;
  logic [WORD-1:0]      skid_pc;
  logic [INSTR_LEN-1:0] skid_instr;

  logic                 redir, misalign, pop, ret;
  logic [2:0]           occ;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  // Once faulted, redirects are ignored until reset.
  assign redir    = redirect_valid & ~fault_q;
  assign misalign = redir & (|redirect_target[1:0]);
`else
  logic unused_fault;
  assign redir        = redirect_valid;
  assign misalign     = 1'b0;
  assign unused_fault = 1'b0;
`endif

  assign pop = out_valid_q & out_ready;
  // Word on imem_instruction this cycle belongs to us and is not squashed.
  assign ret = pending_q & ~squash_q;
  assign occ = {2'b0, out_valid_q} + {2'b0, skid_valid} + {2'b0, pending_q};

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (skid_flush),
    .push       (skid_push),
    .pop        (skid_pop),
    .push_pc    (pending_pc_q),
    .push_instr (imem_instruction),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // Redirect handling, return routing, issue decision and FSM next state.
  always_comb begin
    pc_d         = pc_q;
    out_valid_d  = out_valid_q & ~pop;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    pending_d    = 1'b0;
    pending_pc_d = pending_pc_q;
    squash_d     = 1'b0;
    state_d      = state_q;
    skid_flush   = 1'b0;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d      = fault_q;
`endif
    if (redir) begin
      // Any transfer at pop still completes; everything younger is dropped,
      // including the word returning this cycle. No issue this cycle.
      out_valid_d = 1'b0;
      skid_flush  = 1'b1;
      squash_d    = pending_q;
      if (misalign) begin
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = 1'b1;
`endif
        state_d = ST_DRAIN;
      end else begin
        pc_d = redirect_target & ~WORD'(3);
        if (redirect_target < LIMIT)
          state_d = ST_RUN;
        else if (state_q != ST_HALTED)
          state_d = ST_DRAIN;
      end
    end else begin
      // Keep order: a held skid word always reaches the output first.
      if (skid_valid) begin
        if (pop) begin
          out_valid_d = 1'b1;
          out_pc_d    = skid_pc;
          out_instr_d = skid_instr;
          skid_pop    = 1'b1;
          skid_push   = ret;
        end
      end else if (!out_valid_q || pop) begin
        if (ret) begin
          out_valid_d = 1'b1;
          out_pc_d    = pending_pc_q;
          out_instr_d = imem_instruction;
        end
      end else begin
        skid_push = ret;
      end

      case (state_q)
        ST_RUN: begin
          if (pc_q >= LIMIT) begin
            state_d = ST_DRAIN;
          end else if (occ < (3'd2 + {2'b0, pop})) begin
            pending_d    = 1'b1;
            pending_pc_d = pc_q;
            pc_d         = pc_q + WORD'(INSTR_BYTES);
          end
        end
        ST_DRAIN: begin
          if (!out_valid_q && !skid_valid && !pending_q)
            state_d = ST_HALTED;
        end
        default: ;
      endcase
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      squash_q     <= 1'b0;
      state_q      <= ST_RUN;
    end else begin
      pc_q         <= pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      squash_q     <= squash_d;
      state_q      <= state_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky alignment fault, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
`endif

  assign imem_address    = pc_q;
  assign out_valid       = out_valid_q;
  assign out_instruction = out_instr_q;
  assign out_pc          = out_pc_q;
  assign halted          = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a full-size instance and a 16-word
// instance, each fed by a memory model where word i holds value i.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Full-size DUT
  logic [31:0] addr_b, instr_b, oi_b, op_b, tgt_b;
  logic        ready_b, redir_b, ov_b, h_b;
  // Small (16-word) DUT
  logic [31:0] addr_s, instr_s, oi_s, op_s, tgt_s;
  logic        ready_s, redir_s, ov_s, h_s;

  int total = 0;
  int fails = 0;

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(1024)) dut_b (
    .clk(clk), .reset(reset), .imem_address(addr_b), .imem_instruction(instr_b),
    .out_valid(ov_b), .out_ready(ready_b), .out_instruction(oi_b), .out_pc(op_b),
    .redirect_valid(redir_b), .redirect_target(tgt_b), .halted(h_b));

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(16)) dut_s (
    .clk(clk), .reset(reset), .imem_address(addr_s), .imem_instruction(instr_s),
    .out_valid(ov_s), .out_ready(ready_s), .out_instruction(oi_s), .out_pc(op_s),
    .redirect_valid(redir_s), .redirect_target(tgt_s), .halted(h_s));

  // Instruction memories: registered read, word i = i.
  always @(posedge clk) begin
    instr_b <= addr_b >> 2;
    instr_s <= addr_s >> 2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ready_b = 1'b1; redir_b = 1'b0; tgt_b = '0;
    ready_s = 1'b1; redir_s = 1'b0; tgt_s = '0;
    repeat (3) step();

    // Reset state
    check("rst_valid", 32'(ov_b), 32'd0);
    check("rst_halted", 32'(h_b), 32'd0);
    check("rst_addr", addr_b, 32'h0);
    check("rst_pc", op_b, 32'h0);
    check("rst_instr", oi_b, 32'h0);

    // Stream from reset: first word two cycles after issue, then no gaps
    reset = 1'b0;
    step();
    check("lat_valid", 32'(ov_b), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("seq_valid", 32'(ov_b), 32'd1);
      check("seq_pc", op_b, 32'(4 * i));
      check("seq_instr", oi_b, 32'(i));
      if (i < 3) step();
    end

    // Backpressure while instr 3 is presented
    ready_b = 1'b0;
    repeat (5) begin
      step();
      check("bp_valid", 32'(ov_b), 32'd1);
      check("bp_instr", oi_b, 32'd3);
      check("bp_addr_bound", 32'(addr_b <= 32'h14), 32'd1);
    end
    ready_b = 1'b1;
    for (int i = 4; i < 7; i++) begin
      step();
      check("bp_rel_valid", 32'(ov_b), 32'd1);
      check("bp_rel_pc", op_b, 32'(4 * i));
      check("bp_rel_instr", oi_b, 32'(i));
    end

    // Reset while stalled with the skid full
    ready_b = 1'b0;
    repeat (3) step();
    check("stall_hold", oi_b, 32'd6);
    reset = 1'b1;
    step();
    check("midrst_valid", 32'(ov_b), 32'd0);
    check("midrst_addr", addr_b, 32'h0);
    reset = 1'b0;
    ready_b = 1'b1;
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      check("restart_valid", 32'(ov_b), 32'd1);
      check("restart_pc", op_b, 32'(4 * i));
      check("restart_instr", oi_b, 32'(i));
      if (i < 5) step();
    end

    // Redirect to 0x100 while instr 5 is valid
    redir_b = 1'b1; tgt_b = 32'h100;
    step();
    redir_b = 1'b0;
    check("redir_bubble0", 32'(ov_b), 32'd0);
    step();
    check("redir_bubble1", 32'(ov_b), 32'd0);
    step();
    check("redir_valid", 32'(ov_b), 32'd1);
    check("redir_pc", op_b, 32'h100);
    check("redir_instr", oi_b, 32'd64);

    // Misaligned redirect target
    redir_b = 1'b1; tgt_b = 32'h102;
    step();
    redir_b = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    step();
    check("fault_halted", 32'(h_b), 32'd1);
    check("fault_valid", 32'(ov_b), 32'd0);
    redir_b = 1'b1; tgt_b = 32'h0;
    step();
    redir_b = 1'b0;
    repeat (3) step();
    check("fault_sticky_halted", 32'(h_b), 32'd1);
    check("fault_sticky_valid", 32'(ov_b), 32'd0);
`else
    step();
    step();
    check("mis_valid", 32'(ov_b), 32'd1);
    check("mis_pc", op_b, 32'h100);
    check("mis_instr", oi_b, 32'd64);
    step();
    check("mis_next_pc", op_b, 32'h104);
    check("mis_next_instr", oi_b, 32'd65);
`endif

    // End-of-memory halt on the 16-word instance
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      check("eom_valid", 32'(ov_s), 32'd1);
      check("eom_pc", op_s, 32'(4 * i));
      check("eom_instr", oi_s, 32'(i));
      step();
    end
    check("eom_drained", 32'(ov_s), 32'd0);
    step();
    check("eom_halted", 32'(h_s), 32'd1);
    check("eom_halt_valid", 32'(ov_s), 32'd0);
    redir_s = 1'b1; tgt_s = 32'h8;
    step();
    redir_s = 1'b0;
    check("resume_halted", 32'(h_s), 32'd0);
    step();
    step();
    check("resume_valid", 32'(ov_s), 32'd1);
    check("resume_pc", op_s, 32'h8);
    check("resume_instr", oi_s, 32'd2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
